universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 100 ++++++++++
 tb/tb_universal_shift_register.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: shift, rotate, load, clear, with a shared shift counter and word-done pulse.
// Latency: one clk edge for all outputs; serial outputs are taps of the register.
module universal_shift_register #(
  parameter int WIDTH = 8,
  localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CNT_W-1:0] shift_count,
  output logic             word_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             counted;

  always_comb begin
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    counted = 1'b0;
    if (enable) begin
      unique case (mode)
        MODE_SHR: begin
          reg_d   = {serial_in_r, reg_q[WIDTH-1:1]};
          counted = 1'b1;
        end
        MODE_SHL: begin
          reg_d   = {reg_q[WIDTH-2:0], serial_in_l};
          counted = 1'b1;
        end
        MODE_ROR: begin
          reg_d   = {reg_q[0], reg_q[WIDTH-1:1]};
          counted = 1'b1;
        end
        MODE_ROL: begin
          reg_d   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
          counted = 1'b1;
        end
        MODE_LOAD: begin
          reg_d = parallel_in;
          cnt_d = '0;
        end
        MODE_CLR: begin
          reg_d = '0;
          cnt_d = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
      // All four shift/rotate modes feed one shared counter; the WIDTH-th op wraps it.
      if (counted) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign parallel_out = reg_q;
  assign serial_out_r = reg_q[0];
  assign serial_out_l = reg_q[WIDTH-1];
  assign shift_count  = cnt_q;
  assign word_done    = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH=8; each task checks its own scenario.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [2:0]       mode;
  logic             serial_in_r;
  logic             serial_in_l;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_r;
  logic             serial_out_l;
  logic [CNT_W-1:0] shift_count;
  logic             word_done;

  int n_checks = 0;
  int n_fail   = 0;

  universal_shift_register #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .serial_in_r  (serial_in_r),
    .serial_in_l  (serial_in_l),
    .parallel_in  (parallel_in),
    .parallel_out (parallel_out),
    .serial_out_r (serial_out_r),
    .serial_out_l (serial_out_l),
    .shift_count  (shift_count),
    .word_done    (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation and advance to 1 time unit after the edge that samples it.
  task automatic op(input logic en, input logic [2:0] m);
    enable = en;
    mode   = m;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mode = 3'b000;
    serial_in_r = 1'b0; serial_in_l = 1'b0; parallel_in = '0;
    #3;
    n_checks++;
    if (parallel_out !== 8'h00 || shift_count !== 3'd0 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h cnt=%0d wd=%b, required 00/0/0", parallel_out, shift_count, word_done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    parallel_in = 8'hFF;
    op(1'b1, 3'b011);
    op(1'b1, 3'b010);  // count=1, so reset must clear a nonzero count
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (parallel_out !== 8'h00 || shift_count !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: out=%h cnt=%0d, required 00/0 before edge", parallel_out, shift_count);
    end
    parallel_in = 8'hAA;
    op(1'b1, 3'b011);
    n_checks++;
    if (parallel_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: out=%h, required 00", parallel_out);
    end
    reset = 1'b0;
    op(1'b1, 3'b011);
    n_checks++;
    if (parallel_out !== 8'hAA) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: out=%h, required aa", parallel_out);
    end
  endtask

  task automatic test_serialize();
    logic [7:0] exp_bits;
    exp_bits = 8'hA5;
    parallel_in = 8'hA5;
    op(1'b1, 3'b011);
    serial_in_r = 1'b0;
    serial_in_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (serial_out_r !== exp_bits[i]) begin
        n_fail++;
        $display("FAIL serialize_bit%0d: serial_out_r=%b, required %b", i, serial_out_r, exp_bits[i]);
      end
      op(1'b1, 3'b001);
      n_checks++;
      if (i < 7 && (word_done !== 1'b0 || shift_count !== 3'(i + 1))) begin
        n_fail++;
        $display("FAIL serialize_count%0d: cnt=%0d wd=%b, required %0d/0", i, shift_count, word_done, i + 1);
      end else if (i == 7 && (word_done !== 1'b1 || shift_count !== 3'd0 || parallel_out !== 8'h00)) begin
        n_fail++;
        $display("FAIL serialize_end: out=%h cnt=%0d wd=%b, required 00/0/1", parallel_out, shift_count, word_done);
      end
    end
    op(1'b1, 3'b000);
    n_checks++;
    if (word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL serialize_pulse_width: wd=%b, required 0", word_done);
    end
  endtask

  task automatic test_rotate();
    serial_in_r = 1'b1;
    serial_in_l = 1'b1;
    parallel_in = 8'h81;
    op(1'b1, 3'b011);
    op(1'b1, 3'b101);
    n_checks++;
    if (parallel_out !== 8'h03 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rotate_left1: out=%h wd=%b, required 03/0", parallel_out, word_done);
    end
    op(1'b1, 3'b101);
    n_checks++;
    if (parallel_out !== 8'h06 || shift_count !== 3'd2) begin
      n_fail++;
      $display("FAIL rotate_left2: out=%h cnt=%0d, required 06/2", parallel_out, shift_count);
    end
    op(1'b1, 3'b011);
    op(1'b1, 3'b100);
    n_checks++;
    if (parallel_out !== 8'hC0 || word_done !== 1'b0 || shift_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rotate_right: out=%h cnt=%0d wd=%b, required c0/1/0", parallel_out, shift_count, word_done);
    end
  endtask

  task automatic test_deserialize();
    op(1'b1, 3'b110);
    serial_in_l = 1'b1;
    serial_in_r = 1'b0;
    for (int i = 0; i < 3; i++) op(1'b1, 3'b010);
    n_checks++;
    if (parallel_out !== 8'h07 || shift_count !== 3'd3) begin
      n_fail++;
      $display("FAIL deserialize: out=%h cnt=%0d, required 07/3", parallel_out, shift_count);
    end
    parallel_in = 8'hFF;
    for (int i = 0; i < 4; i++) op(1'b0, 3'b011);
    n_checks++;
    if (parallel_out !== 8'h07 || shift_count !== 3'd3 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low_hold: out=%h cnt=%0d wd=%b, required 07/3/0", parallel_out, shift_count, word_done);
    end
  endtask

  task automatic test_load_mid_word();
    op(1'b1, 3'b110);
    serial_in_r = 1'b1;
    for (int i = 0; i < 5; i++) op(1'b1, 3'b001);
    n_checks++;
    if (parallel_out !== 8'hF8 || shift_count !== 3'd5) begin
      n_fail++;
      $display("FAIL pre_load_shifts: out=%h cnt=%0d, required f8/5", parallel_out, shift_count);
    end
    parallel_in = 8'h3C;
    op(1'b1, 3'b011);
    n_checks++;
    if (parallel_out !== 8'h3C || shift_count !== 3'd0 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_mid_word: out=%h cnt=%0d wd=%b, required 3c/0/0", parallel_out, shift_count, word_done);
    end
  endtask

  task automatic test_clear_reserved();
    serial_in_l = 1'b0;
    op(1'b1, 3'b010);
    op(1'b1, 3'b110);
    n_checks++;
    if (parallel_out !== 8'h00 || shift_count !== 3'd0) begin
      n_fail++;
      $display("FAIL clear: out=%h cnt=%0d, required 00/0", parallel_out, shift_count);
    end
    serial_in_l = 1'b1;
    op(1'b1, 3'b010);
    parallel_in = 8'hFF;
    op(1'b1, 3'b111);
    op(1'b1, 3'b111);
    n_checks++;
    if (parallel_out !== 8'h01 || shift_count !== 3'd1 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_mode: out=%h cnt=%0d wd=%b, required 01/1/0", parallel_out, shift_count, word_done);
    end
  endtask

  task automatic test_back_to_back();
    parallel_in = 8'h0F;
    op(1'b1, 3'b011);
    serial_in_r = 1'b1;
    for (int i = 0; i < 4; i++) op(1'b1, 3'b001);
    n_checks++;
    if (parallel_out !== 8'hF0 || shift_count !== 3'd4) begin
      n_fail++;
      $display("FAIL mixed_shift_half: out=%h cnt=%0d, required f0/4", parallel_out, shift_count);
    end
    for (int i = 0; i < 4; i++) op(1'b1, 3'b101);
    n_checks++;
    if (parallel_out !== 8'h0F || shift_count !== 3'd0 || word_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mixed_word_done: out=%h cnt=%0d wd=%b, required 0f/0/1", parallel_out, shift_count, word_done);
    end
    op(1'b0, 3'b101);
    n_checks++;
    if (parallel_out !== 8'h0F || shift_count !== 3'd0 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_drop_when_idle: out=%h cnt=%0d wd=%b, required 0f/0/0", parallel_out, shift_count, word_done);
    end
  endtask

  task automatic test_reset_mid_word();
    op(1'b1, 3'b110);
    for (int i = 0; i < 7; i++) op(1'b1, 3'b100);
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    op(1'b1, 3'b100);
    n_checks++;
    if (shift_count !== 3'd1 || word_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_word: cnt=%0d wd=%b, required 1/0", shift_count, word_done);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_serialize();
    test_rotate();
    test_deserialize();
    test_load_mid_word();
    test_clear_reserved();
    test_back_to_back();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
